flash_sample_streamer: RTL and testbench

//  Streams fixed-width samples from byte-wide parallel flash (DE2 FL_* pins) into a prefetch FIFO.

---
 rtl/flash_sample_streamer_pkg.sv | 21 ++
 rtl/flash_sample_streamer_if.sv | 11 +
 rtl/flash_sample_streamer_sample_fifo.sv | 72 +++++++
 rtl/flash_sample_streamer.sv | 175 +++++++++++++++++
 tb/tb_flash_sample_streamer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/flash_sample_streamer_pkg.sv
// Shared types and defaults for the parallel-flash sample streamer.
package flash_pkg;

  localparam int FL_ADDR_W       = 22;
  localparam int FL_WAIT_DEFAULT = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_READ,
    ST_WAIT,
    ST_LOAD,
    ST_ADVANCE
  } fl_state_t;

  // States during which the flash is selected and its outputs enabled.
  function automatic logic is_access(input fl_state_t s);
    return (s == ST_READ) || (s == ST_WAIT) || (s == ST_LOAD);
  endfunction

endpackage

// File: rtl/flash_sample_streamer_if.sv
// Valid/ready sample stream from the flash streamer to its consumer.
interface flash_sample_streamer_if #(
  parameter int SW = 16
) ();
  logic [SW-1:0] data;
  logic          valid;
  logic          ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/flash_sample_streamer_sample_fifo.sv
// Prefetch FIFO with a registered head word; head reads 0 while empty.
module sample_fifo #(
  parameter int SW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [SW-1:0] wdata,
  output logic [SW-1:0] head,
  output logic          head_valid,
  output logic          full,
  output logic          empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [SW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_n;
  logic [CW-1:0] count, count_n;
  logic [SW-1:0] head_n;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // The head register is loaded with the word that will be at the read
  // pointer after this cycle, bypassing storage when it is the one pushed.
  always_comb begin
    count_n  = count;
    rd_ptr_n = rd_ptr;
    head_n   = '0;
    if (do_push && !do_pop)      count_n = count + CW'(1);
    else if (!do_push && do_pop) count_n = count - CW'(1);
    if (do_pop) rd_ptr_n = rd_ptr + PW'(1);
    if (count_n != '0) begin
      if (do_push && count_n == CW'(1)) head_n = wdata;
      else                              head_n = mem[rd_ptr_n];
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head       <= '0;
      head_valid <= 1'b0;
    end else if (flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head       <= '0;
      head_valid <= 1'b0;
    end else begin
      rd_ptr     <= rd_ptr_n;
      count      <= count_n;
      head       <= head_n;
      head_valid <= (count_n != '0);
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/flash_sample_streamer.sv
// Reads a programmable window of byte-wide flash, assembles little-endian
// samples and streams them out through a prefetch FIFO.
module flash_sample_streamer
  import flash_pkg::*;
#(
  parameter int ADDR_W           = FL_ADDR_W,
  parameter int BYTES_PER_SAMPLE = 2,
  parameter int WAIT_CYCLES      = FL_WAIT_DEFAULT,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                    CLOCK_50,
  input  logic                    resetb,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    loop_en,
  input  logic [ADDR_W-1:0]       start_addr,
  input  logic [ADDR_W-1:0]       end_addr,
  output logic                    busy,
  output logic                    done,
  flash_sample_streamer_if.master stream,
  output logic [ADDR_W-1:0]       FL_ADDR,
  inout  wire  [7:0]              FL_DQ,
  output logic                    FL_CE_N,
  output logic                    FL_OE_N,
  output logic                    FL_WE_N,
  output logic                    FL_RST_N
);
  localparam int SW   = 8 * BYTES_PER_SAMPLE;
  localparam int BI_W = 2;
  localparam int WC_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

  fl_state_t         state, state_n;
  logic [ADDR_W-1:0] addr, win_start, win_end;
  logic              loop_q;
  logic [BI_W-1:0]   byte_idx, byte_idx_n;
  logic [WC_W-1:0]   wait_cnt;
  logic [SW-1:0]     asm_q, asm_n;
  logic              access_q;

  logic ld_win, push, adv_wrap, adv_step, done_set, flush;
  logic fifo_full, fifo_empty;

  assign FL_DQ    = 'z;
  assign FL_WE_N  = 1'b1;
  assign FL_RST_N = 1'b1;
  assign FL_CE_N  = !access_q;
  assign FL_OE_N  = !access_q;

  always_comb begin
    state_n    = state;
    byte_idx_n = byte_idx;
    asm_n      = asm_q;
    ld_win     = 1'b0;
    push       = 1'b0;
    adv_wrap   = 1'b0;
    adv_step   = 1'b0;
    done_set   = 1'b0;
    flush      = 1'b0;
    case (state)
      ST_IDLE: begin
        byte_idx_n = '0;
        if (start) begin
          ld_win = 1'b1;
          if (end_addr < start_addr) done_set = 1'b1;
          else                       state_n  = ST_CHECK;
        end
      end
      ST_CHECK: if (!fifo_full) state_n = ST_READ;
      ST_READ:  state_n = ST_WAIT;
      ST_WAIT:  if (wait_cnt == WC_W'(WAIT_CYCLES - 1)) state_n = ST_LOAD;
      ST_LOAD: begin
        for (int unsigned b = 0; b < BYTES_PER_SAMPLE; b++) begin
          if (byte_idx == BI_W'(b)) asm_n[8*b +: 8] = FL_DQ;
        end
        if (byte_idx != BI_W'(BYTES_PER_SAMPLE - 1)) begin
          byte_idx_n = byte_idx + BI_W'(1);
          state_n    = ST_READ;
        end else begin
          push    = 1'b1;
          state_n = ST_ADVANCE;
        end
      end
      ST_ADVANCE: begin
        byte_idx_n = '0;
        state_n    = ST_CHECK;
        if (addr == win_end) begin
          if (loop_q) begin
            adv_wrap = 1'b1;
          end else begin
            done_set = 1'b1;
            state_n  = ST_IDLE;
          end
        end else begin
          adv_step = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (abort) begin
      state_n    = ST_IDLE;
      byte_idx_n = '0;
      flush      = 1'b1;
      push       = 1'b0;
      ld_win     = 1'b0;
      adv_wrap   = 1'b0;
      adv_step   = 1'b0;
      done_set   = 1'b0;
    end
  end

  // Strobes and pin levels are registered from the next state so that the
  // pins change on the same edge as the state that owns them.
  always_ff @(posedge CLOCK_50 or negedge resetb) begin
    if (!resetb) begin
      state     <= ST_IDLE;
      addr      <= '0;
      win_start <= '0;
      win_end   <= '0;
      loop_q    <= 1'b0;
      byte_idx  <= '0;
      asm_q     <= '0;
      access_q  <= 1'b0;
      FL_ADDR   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state    <= state_n;
      byte_idx <= byte_idx_n;
      asm_q    <= asm_n;
      access_q <= is_access(state_n);
      busy     <= (state_n != ST_IDLE);
      done     <= done_set;
      if (ld_win) begin
        win_start <= start_addr;
        win_end   <= end_addr;
        loop_q    <= loop_en;
        addr      <= start_addr;
      end else if (adv_wrap) begin
        addr <= win_start;
      end else if (adv_step) begin
        addr <= addr + ADDR_W'(BYTES_PER_SAMPLE);
      end
      if (state_n == ST_READ) FL_ADDR <= addr + ADDR_W'(byte_idx_n);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetb) begin
    if (!resetb)                 wait_cnt <= '0;
    else if (state != ST_WAIT)   wait_cnt <= '0;
    else                         wait_cnt <= wait_cnt + WC_W'(1);
  end

  logic [SW-1:0] fifo_head;
  logic          fifo_valid;

  sample_fifo #(
    .SW    (SW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (CLOCK_50),
    .resetb     (resetb),
    .push       (push),
    .pop        (stream.ready && !fifo_empty),
    .flush      (flush),
    .wdata      (asm_n),
    .head       (fifo_head),
    .head_valid (fifo_valid),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign stream.data  = fifo_head;
  assign stream.valid = fifo_valid;

endmodule

// File: tb/tb_flash_sample_streamer.sv
// Directed bench: flash model with 110-unit access time, window vector table
// plus stall, loop, abort, reset and 3-byte sample sequences.
module tb_flash_sample_streamer;
  localparam int AW = 22;

  logic          clk = 1'b0;
  logic          resetb, start, start3, abort, loop_en;
  logic [AW-1:0] start_addr, end_addr;
  logic          busy, done, busy3, done3;
  logic [AW-1:0] fl_addr, fl_addr3;
  wire  [7:0]    fl_dq, fl_dq3;
  logic          ce_n, oe_n, we_n, rst_n, ce_n3, oe_n3, we_n3, rst_n3;

  flash_sample_streamer_if #(.SW(16)) sif ();
  flash_sample_streamer_if #(.SW(24)) sif3 ();

  flash_sample_streamer #(
    .ADDR_W(AW), .BYTES_PER_SAMPLE(2), .WAIT_CYCLES(6), .FIFO_DEPTH(4)
  ) dut (
    .CLOCK_50(clk), .resetb(resetb), .start(start), .abort(abort),
    .loop_en(loop_en), .start_addr(start_addr), .end_addr(end_addr),
    .busy(busy), .done(done), .stream(sif.master),
    .FL_ADDR(fl_addr), .FL_DQ(fl_dq), .FL_CE_N(ce_n), .FL_OE_N(oe_n),
    .FL_WE_N(we_n), .FL_RST_N(rst_n)
  );

  flash_sample_streamer #(
    .ADDR_W(AW), .BYTES_PER_SAMPLE(3), .WAIT_CYCLES(6), .FIFO_DEPTH(4)
  ) dut3 (
    .CLOCK_50(clk), .resetb(resetb), .start(start3), .abort(abort),
    .loop_en(loop_en), .start_addr(start_addr), .end_addr(end_addr),
    .busy(busy3), .done(done3), .stream(sif3.master),
    .FL_ADDR(fl_addr3), .FL_DQ(fl_dq3), .FL_CE_N(ce_n3), .FL_OE_N(oe_n3),
    .FL_WE_N(we_n3), .FL_RST_N(rst_n3)
  );

  always #10 clk = ~clk;

  // Flash model: data only becomes valid 110 time units after the last
  // change of address or enables; before that it returns 0xEE.
  logic [7:0] mem [256];
  realtime    tchg, tchg3;
  logic       ok = 1'b0, ok3 = 1'b0;
  always @(fl_addr or ce_n or oe_n)    tchg  = $realtime;
  always @(fl_addr3 or ce_n3 or oe_n3) tchg3 = $realtime;
  always @(negedge clk) begin
    ok  = ($realtime - tchg)  >= 110.0;
    ok3 = ($realtime - tchg3) >= 110.0;
  end
  assign fl_dq  = (!ce_n && !oe_n)   ? (ok  ? mem[fl_addr[7:0]]  : 8'hEE) : 8'hzz;
  assign fl_dq3 = (!ce_n3 && !oe_n3) ? (ok3 ? mem[fl_addr3[7:0]] : 8'hEE) : 8'hzz;

  int          ce_cnt = 0, ce3_cnt = 0, done_cnt = 0, done3_cnt = 0, busy_cnt = 0, busy3_cnt = 0;
  logic [31:0] rx_q[$];
  logic [31:0] rx3_q[$];
  always @(negedge clk) begin
    if (!ce_n)  ce_cnt++;
    if (!ce_n3) ce3_cnt++;
    if (done)   done_cnt++;
    if (done3)  done3_cnt++;
    if (busy)   busy_cnt++;
    if (busy3)  busy3_cnt++;
    if (sif.valid && sif.ready)   rx_q.push_back(32'(sif.data));
    if (sif3.valid && sif3.ready) rx3_q.push_back(32'(sif3.data));
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] sa, input logic [7:0] ea, input logic lp, input logic which3);
    start_addr = AW'(sa);
    end_addr   = AW'(ea);
    loop_en    = lp;
    if (which3) start3 = 1'b1; else start = 1'b1;
    tick(1);
    start  = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic wait_done(input int base, input int limit, input string name);
    int k = 0;
    while (done_cnt == base && k < limit) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(done_cnt - base), 32'd1);
    tick(1);
  endtask

  typedef struct {
    logic [7:0]  sa;
    logic [7:0]  ea;
    int          nsamp;
    logic [31:0] first;
    logic [31:0] last;
    int          ce;
    int          busy_cyc;
  } vec_t;

  vec_t vt[5];

  initial begin
    int ce0, dn0, bz0, rx0, n;
    logic [31:0] exp_w;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[8'h10] = 8'h34; mem[8'h11] = 8'h12;
    mem[8'h70] = 8'h01; mem[8'h71] = 8'h02; mem[8'h72] = 8'h03;

    vt[0] = '{8'h10, 8'h10, 1, 32'h1234, 32'h1234, 16, 18};
    vt[1] = '{8'h20, 8'h24, 3, 32'h2120, 32'h2524, 48, 54};
    vt[2] = '{8'h31, 8'h33, 2, 32'h3231, 32'h3433, 32, 36};
    vt[3] = '{8'h50, 8'h40, 0, 32'h0,    32'h0,     0,  0};
    vt[4] = '{8'h7E, 8'h80, 2, 32'h7F7E, 32'h8180, 32, 36};

    start = 0; start3 = 0; abort = 0; loop_en = 0;
    start_addr = '0; end_addr = '0;
    sif.ready = 1'b1; sif3.ready = 1'b1;
    resetb = 1'b1;
    #1 resetb = 1'b0;
    #4;
    check("rst_ce_n",  32'(ce_n), 32'd1);
    check("rst_oe_n",  32'(oe_n), 32'd1);
    check("rst_addr",  32'(fl_addr), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_valid", 32'(sif.valid), 32'd0);
    check("rst_data",  32'(sif.data), 32'd0);
    check("we_n_tied", 32'(we_n), 32'd1);
    check("rst_n_tied", 32'(rst_n), 32'd1);
    #20 resetb = 1'b1;
    tick(2);

    // One-shot windows
    for (int i = 0; i < 5; i++) begin
      ce0 = ce_cnt; dn0 = done_cnt; bz0 = busy_cnt; rx0 = rx_q.size();
      pulse(vt[i].sa, vt[i].ea, 1'b0, 1'b0);
      wait_done(dn0, 400, $sformatf("v%0d_done", i));
      tick(6);
      check($sformatf("v%0d_nsamp", i), 32'(rx_q.size() - rx0), 32'(vt[i].nsamp));
      if (vt[i].nsamp > 0 && rx_q.size() >= rx0 + vt[i].nsamp) begin
        check($sformatf("v%0d_first", i), rx_q[rx0], vt[i].first);
        check($sformatf("v%0d_last", i), rx_q[rx0 + vt[i].nsamp - 1], vt[i].last);
      end
      check($sformatf("v%0d_ce_cycles", i), 32'(ce_cnt - ce0), 32'(vt[i].ce));
      check($sformatf("v%0d_busy_cycles", i), 32'(busy_cnt - bz0), 32'(vt[i].busy_cyc));
      check($sformatf("v%0d_done_pulses", i), 32'(done_cnt - dn0), 32'd1);
    end

    // Backpressure: FIFO fills with 4 of 6 samples, fetch stalls
    sif.ready = 1'b0;
    ce0 = ce_cnt; dn0 = done_cnt; rx0 = rx_q.size();
    pulse(8'h60, 8'h6A, 1'b0, 1'b0);
    tick(120);
    check("stall_ce_cycles", 32'(ce_cnt - ce0), 32'd64);
    check("stall_ce_n", 32'(ce_n), 32'd1);
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_valid", 32'(sif.valid), 32'd1);
    check("stall_head", 32'(sif.data), 32'h6160);
    sif.ready = 1'b1;
    wait_done(dn0, 400, "stall_done");
    tick(6);
    check("stall_nsamp", 32'(rx_q.size() - rx0), 32'd6);
    for (int k = 0; k < 6; k++) begin
      exp_w = {16'h0, 8'(8'h61 + 2*k), 8'(8'h60 + 2*k)};
      if (rx_q.size() > rx0 + k)
        check($sformatf("stall_order%0d", k), rx_q[rx0 + k], exp_w);
    end
    check("stall_ce_total", 32'(ce_cnt - ce0), 32'd96);

    // Loop mode 0,2,0,2,...
    dn0 = done_cnt; rx0 = rx_q.size();
    pulse(8'h00, 8'h02, 1'b1, 1'b0);
    tick(200);
    n = rx_q.size() - rx0;
    check("loop_count_ge8", 32'(n >= 8), 32'd1);
    for (int k = 0; k < 8; k++) begin
      if (n > k)
        check($sformatf("loop_s%0d", k), rx_q[rx0 + k], (k % 2 == 1) ? 32'h0302 : 32'h0100);
    end
    check("loop_no_done", 32'(done_cnt - dn0), 32'd0);
    check("loop_busy", 32'(busy), 32'd1);
    abort = 1'b1; tick(1); abort = 1'b0; loop_en = 1'b0;
    check("loop_abort_busy", 32'(busy), 32'd0);
    check("loop_abort_ce_n", 32'(ce_n), 32'd1);
    tick(2);

    // Abort during WAIT of the 2nd byte of the 2nd sample, with a sample queued
    sif.ready = 1'b0;
    dn0 = done_cnt; rx0 = rx_q.size();
    pulse(8'h20, 8'h22, 1'b0, 1'b0);
    n = 0;
    while (!(fl_addr == AW'(8'h23) && !ce_n) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_byte2", 32'(fl_addr), 32'h23);
    @(posedge clk); #1;
    check("abort_pre_valid", 32'(sif.valid), 32'd1);
    abort = 1'b1; tick(1); abort = 1'b0;
    check("abort_ce_n", 32'(ce_n), 32'd1);
    check("abort_oe_n", 32'(oe_n), 32'd1);
    check("abort_valid", 32'(sif.valid), 32'd0);
    check("abort_data", 32'(sif.data), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    sif.ready = 1'b1;
    tick(40);
    check("abort_no_rx", 32'(rx_q.size() - rx0), 32'd0);
    check("abort_no_done", 32'(done_cnt - dn0), 32'd0);
    rx0 = rx_q.size();
    pulse(8'h22, 8'h22, 1'b0, 1'b0);
    wait_done(dn0, 200, "restart_done");
    tick(4);
    check("restart_nsamp", 32'(rx_q.size() - rx0), 32'd1);
    if (rx_q.size() > rx0) check("restart_data", rx_q[rx0], 32'h2322);

    // Asynchronous reset in the middle of READ
    pulse(8'h30, 8'h30, 1'b0, 1'b0);
    n = 0;
    while (ce_n && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_read_ce_low", 32'(ce_n), 32'd0);
    #2 resetb = 1'b0;
    #1;
    check("mid_rst_ce_n", 32'(ce_n), 32'd1);
    check("mid_rst_oe_n", 32'(oe_n), 32'd1);
    check("mid_rst_addr", 32'(fl_addr), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(sif.valid), 32'd0);
    #4 resetb = 1'b1;
    tick(3);

    // Three-byte samples
    ce0 = ce3_cnt; dn0 = done3_cnt; bz0 = busy3_cnt; rx0 = rx3_q.size();
    pulse(8'h70, 8'h70, 1'b0, 1'b1);
    n = 0;
    while (done3_cnt == dn0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    tick(4);
    check("b3_done", 32'(done3_cnt - dn0), 32'd1);
    check("b3_nsamp", 32'(rx3_q.size() - rx0), 32'd1);
    if (rx3_q.size() > rx0) check("b3_data", rx3_q[rx0], 32'h030201);
    check("b3_ce_cycles", 32'(ce3_cnt - ce0), 32'd24);
    check("b3_busy_cycles", 32'(busy3_cnt - bz0), 32'd26);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
